// File: rtl/serial_addsub_fsm.sv
// Bit-serial adder/subtractor: latches two operands on start and then
// resolves one bit per clock, LSB first, through a single full adder and
// a carry register. It streams each sum bit and assembles the parallel
// result, carry-out and signed overflow. A done pulse follows the last bit.
module serial_addsub_fsm #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             s_bit,
  output logic             s_vld,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;      // operand B, already inverted for subtract
  logic             c_q, c_d;      // carry into the current bit
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             a_bit;
  logic             b_bit;
  logic             fa_sum;
  logic             fa_carry;

  // Single full adder on the bit currently selected by the counter
  always_comb begin
    a_bit    = a_q[cnt_q];
    b_bit    = b_q[cnt_q];
    fa_sum   = a_bit ^ b_bit ^ c_q;
    fa_carry = (a_bit & b_bit) | ((a_bit ^ b_bit) & c_q);
  end

  // Next-state and datapath update for the IDLE -> RUN -> DONE sequence
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          c_d     = sub ? 1'b1 : cin;
          cnt_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        c_d          = fa_carry;
        sum_d[cnt_q] = fa_sum;
        if (cnt_q == LAST_BIT) begin
          // Counter parks at zero instead of wrapping past the last bit
          cnt_d   = '0;
          cout_d  = fa_carry;
          ovf_d   = c_q ^ fa_carry;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Serial bit is only meaningful while running; hold it low otherwise
  always_comb begin
    busy  = busy_q;
    s_vld = busy_q;
    s_bit = busy_q & fa_sum;
    done  = done_q;
    sum   = sum_q;
    cout  = cout_q;
    ovf   = ovf_q;
  end

endmodule

// File: tb/tb_serial_addsub_fsm.sv
// Directed and random checks for the bit-serial adder/subtractor at WIDTH = 8.
module tb_serial_addsub_fsm;

  logic       clk;
  logic       rst;
  logic       start;
  logic       sub;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       s_bit;
  logic       s_vld;
  logic       done;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;

  int checks;
  int failures;

  // Results captured by run_op
  logic [7:0] r_sum;
  logic       r_cout;
  logic       r_ovf;
  logic [7:0] r_sbits;
  int         r_nvld;
  int         r_lat;
  logic       r_busy_bad;

  serial_addsub_fsm #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .sub  (sub),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .s_bit(s_bit),
    .s_vld(s_vld),
    .done (done),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one operation and observe it until done (bounded).
  // glitch_at > 0 pulses start with scrambled operands on that RUN cycle.
  task automatic run_op(input logic op_sub, input logic [7:0] op_a, input logic [7:0] op_b,
                        input logic op_cin, input int glitch_at);
    r_nvld     = 0;
    r_sbits    = '0;
    r_lat      = -1;
    r_busy_bad = 1'b0;
    r_sum      = 'x;
    r_cout     = 1'bx;
    r_ovf      = 1'bx;
    @(negedge clk);
    sub   = op_sub;
    a     = op_a;
    b     = op_b;
    cin   = op_cin;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (s_vld === 1'b1) begin
        if (r_nvld < 8) r_sbits[r_nvld] = s_bit;
        r_nvld++;
      end
      if (busy !== s_vld) r_busy_bad = 1'b1;
      if (done === 1'b1) begin
        r_lat  = k;
        r_sum  = sum;
        r_cout = cout;
        r_ovf  = ovf;
        break;
      end
      if (k == glitch_at) begin
        start = 1'b1;
        a     = ~op_a;
        b     = op_a ^ 8'h33;
        sub   = ~op_sub;
        cin   = ~op_cin;
      end else if (k == glitch_at + 1) begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, s_vld, done, cout, ovf} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags: got busy/s_vld/done/cout/ovf=%b, want 00000",
               {busy, s_vld, done, cout, ovf});
    end
    checks++;
    if (sum !== 8'h00) begin
      failures++;
      $display("FAIL reset_sum: got %h, want 00", sum);
    end
  endtask

  task automatic test_add_basic();
    run_op(1'b0, 8'h5A, 8'h3C, 1'b0, 0);
    checks++;
    if (r_sbits !== 8'h96) begin
      failures++;
      $display("FAIL add5A3C_stream: got bits(LSB=bit0) %b, want 10010110", r_sbits);
    end
    checks++;
    if ({r_sum, r_cout, r_ovf} !== {8'h96, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL add5A3C_result: got sum=%h cout=%b ovf=%b, want 96 0 1", r_sum, r_cout, r_ovf);
    end
    checks++;
    if (r_lat !== 9) begin
      failures++;
      $display("FAIL add5A3C_latency: got %0d, want 9", r_lat);
    end
    checks++;
    if (r_nvld !== 8 || r_busy_bad) begin
      failures++;
      $display("FAIL add5A3C_svld: got %0d valid cycles busy_bad=%b, want 8 0", r_nvld, r_busy_bad);
    end

    run_op(1'b0, 8'hFF, 8'h01, 1'b0, 0);
    checks++;
    if ({r_sum, r_cout, r_ovf} !== {8'h00, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL addFF01: got sum=%h cout=%b ovf=%b, want 00 1 0", r_sum, r_cout, r_ovf);
    end

    run_op(1'b0, 8'h7F, 8'h00, 1'b1, 0);
    checks++;
    if ({r_sum, r_cout, r_ovf} !== {8'h80, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL add7F00c1: got sum=%h cout=%b ovf=%b, want 80 0 1", r_sum, r_cout, r_ovf);
    end
  endtask

  task automatic test_sub_basic();
    run_op(1'b1, 8'h10, 8'h20, 1'b0, 0);
    checks++;
    if ({r_sum, r_cout, r_ovf} !== {8'hF0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL sub1020: got sum=%h cout=%b ovf=%b, want F0 0 0", r_sum, r_cout, r_ovf);
    end

    run_op(1'b1, 8'h05, 8'h05, 1'b1, 0);
    checks++;
    if ({r_sum, r_cout, r_ovf} !== {8'h00, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL sub0505_cin1: got sum=%h cout=%b ovf=%b, want 00 1 0", r_sum, r_cout, r_ovf);
    end

    run_op(1'b1, 8'h80, 8'h01, 1'b0, 0);
    checks++;
    if ({r_sum, r_cout, r_ovf} !== {8'h7F, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL sub8001: got sum=%h cout=%b ovf=%b, want 7F 1 1", r_sum, r_cout, r_ovf);
    end
  endtask

  task automatic test_back_to_back();
    int extra;
    run_op(1'b0, 8'h5A, 8'h3C, 1'b0, 3);
    checks++;
    if ({r_sum, r_cout, r_ovf} !== {8'h96, 1'b0, 1'b1} || r_lat !== 9) begin
      failures++;
      $display("FAIL glitch_first_result: got sum=%h cout=%b ovf=%b lat=%0d, want 96 0 1 9",
               r_sum, r_cout, r_ovf, r_lat);
    end
    // The dropped start must not have launched a hidden second operation
    extra = 0;
    repeat (2) begin
      @(negedge clk);
      if (busy !== 1'b0 || s_vld !== 1'b0 || done !== 1'b0) extra++;
    end
    checks++;
    if (extra !== 0) begin
      failures++;
      $display("FAIL glitch_dropped: got %0d active cycles after done, want 0", extra);
    end

    // Start in the cycle immediately after done is accepted
    run_op(1'b0, 8'h21, 8'h43, 1'b0, 0);
    run_op(1'b1, 8'h64, 8'h14, 1'b0, 0);
    checks++;
    if ({r_sum, r_cout, r_ovf} !== {8'h50, 1'b1, 1'b0} || r_lat !== 9) begin
      failures++;
      $display("FAIL after_done_start: got sum=%h cout=%b ovf=%b lat=%0d, want 50 1 0 9",
               r_sum, r_cout, r_ovf, r_lat);
    end
  endtask

  task automatic test_reset_midrun();
    int bad_done;
    run_op(1'b1, 8'h80, 8'h01, 1'b0, 0); // leaves cout=1 ovf=1
    @(negedge clk);
    sub   = 1'b0;
    a     = 8'h5A;
    b     = 8'h3C;
    cin   = 1'b0;
    start = 1'b1;
    @(negedge clk);                      // RUN cycle 1
    start = 1'b0;
    repeat (3) @(negedge clk);           // RUN cycle 4
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, s_vld, done, cout, ovf} !== 5'b0) begin
      failures++;
      $display("FAIL midrun_reset_flags: got busy/s_vld/done/cout/ovf=%b, want 00000",
               {busy, s_vld, done, cout, ovf});
    end
    checks++;
    if (sum !== 8'h00) begin
      failures++;
      $display("FAIL midrun_reset_sum: got %h, want 00", sum);
    end
    bad_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bad_done++;
    end
    checks++;
    if (bad_done !== 0) begin
      failures++;
      $display("FAIL midrun_no_done: got %0d active cycles after reset, want 0", bad_done);
    end
    run_op(1'b0, 8'h12, 8'h34, 1'b1, 0);
    checks++;
    if ({r_sum, r_cout, r_ovf} !== {8'h47, 1'b0, 1'b0} || r_lat !== 9) begin
      failures++;
      $display("FAIL after_reset_add: got sum=%h cout=%b ovf=%b lat=%0d, want 47 0 0 9",
               r_sum, r_cout, r_ovf, r_lat);
    end
  endtask

  task automatic test_random();
    logic [7:0] ra, rb, bb;
    logic       rs, rc, c0, exp_cout, exp_ovf, c7;
    logic [8:0] full;
    logic [7:0] low7;
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      rc = 1'($urandom);
      bb = rs ? ~rb : rb;
      c0 = rs ? 1'b1 : rc;
      full     = {1'b0, ra} + {1'b0, bb} + {8'b0, c0};
      low7     = {1'b0, ra[6:0]} + {1'b0, bb[6:0]} + {7'b0, c0};
      c7       = low7[7];
      exp_cout = full[8];
      exp_ovf  = c7 ^ exp_cout;
      run_op(rs, ra, rb, rc, 0);
      checks++;
      if ({r_sum, r_cout, r_ovf} !== {full[7:0], exp_cout, exp_ovf}) begin
        failures++;
        $display("FAIL rnd_result #%0d a=%h b=%h sub=%b cin=%b: got %h %b %b, want %h %b %b",
                 n, ra, rb, rs, rc, r_sum, r_cout, r_ovf, full[7:0], exp_cout, exp_ovf);
      end
      checks++;
      if (r_sbits !== full[7:0]) begin
        failures++;
        $display("FAIL rnd_stream #%0d: got %b, want %b", n, r_sbits, full[7:0]);
      end
      checks++;
      if (r_nvld !== 8 || r_busy_bad || r_lat !== 9) begin
        failures++;
        $display("FAIL rnd_timing #%0d: got vld=%0d busy_bad=%b lat=%0d, want 8 0 9",
                 n, r_nvld, r_busy_bad, r_lat);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_add_basic();
    test_sub_basic();
    test_back_to_back();
    test_reset_midrun();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
